// File: rtl/lcg_stim_gen.sv
// lcg_stim_gen -- on-chip stimulus source for the fuzz DUT `top`.
//
// Reproduces the bench generator's 32-bit LCG (s' = s*LCG_MULT + LCG_INC,
// mod 2^32). Each run emits num_vectors vectors of WIDTH bits. A vector is
// built one LCG word per cycle, low word first, and then offered on a
// valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   seed_load    load seed_in into the LCG state (IDLE only)
//   seed_in      seed value
//   start        begin a run (IDLE only); num_vectors is latched here
//   num_vectors  vectors per run (0 produces an immediate done)
//   vec_valid    vec_data holds a complete vector
//   vec_ready    consumer accepts the vector (looked at in HOLD only)
//   vec_data     assembled vector; word k = bits [32k+31:32k], top word truncated
//   vec_index    0-based index of the vector in flight
//   busy         high while building or holding a vector
//   done         one-cycle pulse at the end of a run
//   rng_state    current LCG state
module lcg_stim_gen #(
   parameter int          WIDTH        = 140,
   parameter logic [31:0] LCG_MULT     = 32'h41C64E6D,
   parameter logic [31:0] LCG_INC      = 32'h00003039,
   parameter logic [31:0] DEFAULT_SEED = 32'd2167613558
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             start,
   input  logic [15:0]      num_vectors,
   output logic             vec_valid,
   input  logic             vec_ready,
   output logic [WIDTH-1:0] vec_data,
   output logic [15:0]      vec_index,
   output logic             busy,
   output logic             done,
   output logic [31:0]      rng_state
);

   localparam int WORDS    = (WIDTH + 31) / 32;
   localparam int LOW_BITS = 32 * (WORDS - 1);
   localparam int TOP_BITS = WIDTH - LOW_BITS;
   localparam int CNT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
   // Only the lower WORDS-1 words need storage; the top word goes straight
   // from the LCG into vec_data on the final FILL cycle.
   localparam int BUILD_N  = (WORDS > 1) ? WORDS - 1 : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_HOLD,
      S_DONE
   } state_t;

   state_t             state_q,     state_d;
   logic [31:0]        rng_q,       rng_d;
   logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;
   logic [WIDTH-1:0]   vec_data_q,  vec_data_d;
   logic               vec_valid_q, vec_valid_d;
   logic [15:0]        vec_index_q, vec_index_d;
   logic [15:0]        num_vec_q,   num_vec_d;
   logic               busy_q,      busy_d;
   logic               done_q,      done_d;
   logic [31:0]        build_q [BUILD_N];
   logic [31:0]        build_d [BUILD_N];
   logic [31:0]        rng_next;

   // Multiply and add in a 32-bit context, so wrap-around is implicit.
   assign rng_next = rng_q * LCG_MULT + LCG_INC;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      rng_d       = rng_q;
      word_cnt_d  = word_cnt_q;
      vec_data_d  = vec_data_q;
      vec_valid_d = vec_valid_q;
      vec_index_d = vec_index_q;
      num_vec_d   = num_vec_q;
      build_d     = build_q;

      case (state_q)
         S_IDLE: begin
            // A seed loaded in the same cycle as start is the state the
            // first FILL step works from.
            if (seed_load) begin
               rng_d = seed_in;
            end
            if (start) begin
               num_vec_d   = num_vectors;
               vec_index_d = '0;
               word_cnt_d  = '0;
               state_d     = (num_vectors == 16'd0) ? S_DONE : S_FILL;
            end
         end

         S_FILL: begin
            rng_d = rng_next;
            if (word_cnt_q == CNT_W'(WORDS - 1)) begin
               for (int k = 0; k < WORDS - 1; k++) begin
                  vec_data_d[32*k +: 32] = build_q[k];
               end
               vec_data_d[WIDTH-1:LOW_BITS] = rng_next[TOP_BITS-1:0];
               vec_valid_d = 1'b1;
               word_cnt_d  = '0;
               state_d     = S_HOLD;
            end else begin
               for (int k = 0; k < BUILD_N; k++) begin
                  if (word_cnt_q == CNT_W'(k)) begin
                     build_d[k] = rng_next;
                  end
               end
               word_cnt_d = word_cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (vec_valid_q && vec_ready) begin
               vec_valid_d = 1'b0;
               if (vec_index_q == num_vec_q - 16'd1) begin
                  state_d = S_DONE;
               end else begin
                  vec_index_d = vec_index_q + 16'd1;
                  state_d     = S_FILL;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags are registered decodes of the next state, so they line
      // up with the state they describe.
      busy_d = (state_d == S_FILL) || (state_d == S_HOLD);
      done_d = (state_d == S_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rng_q       <= DEFAULT_SEED;
         word_cnt_q  <= '0;
         vec_data_q  <= '0;
         vec_valid_q <= 1'b0;
         vec_index_q <= '0;
         num_vec_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rng_q       <= rng_d;
         word_cnt_q  <= word_cnt_d;
         vec_data_q  <= vec_data_d;
         vec_valid_q <= vec_valid_d;
         vec_index_q <= vec_index_d;
         num_vec_q   <= num_vec_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // NOTE: the build words are not reset; each is rewritten before it is ever copied out.
   always_ff @(posedge clk) begin
      build_q <= build_d;
   end

   assign vec_valid = vec_valid_q;
   assign vec_data  = vec_data_q;
   assign vec_index = vec_index_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rng_state = rng_q;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb_lcg_stim_gen -- scoreboard bench for lcg_stim_gen.
// Stimulus pushes the expected vectors (from a software LCG) into a queue;
// a monitor on the falling edge pops and compares on every handshake.
module tb_lcg_stim_gen;

   localparam int          WIDTH = 140;
   localparam logic [31:0] MULT  = 32'h41C64E6D;
   localparam logic [31:0] INC   = 32'h00003039;
   localparam logic [31:0] DSEED = 32'd2167613558;

   logic             clk = 1'b0;
   logic             rst;
   logic             seed_load;
   logic [31:0]      seed_in;
   logic             start;
   logic [15:0]      num_vectors;
   logic             vec_valid;
   logic             vec_ready;
   logic [WIDTH-1:0] vec_data;
   logic [15:0]      vec_index;
   logic             busy;
   logic             done;
   logic [31:0]      rng_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int accepts = 0;

   logic [WIDTH-1:0] exp_data_q [$];
   logic [15:0]      exp_idx_q  [$];
   int               hs_cyc     [$];
   logic [31:0]      model_s;

   lcg_stim_gen #(
      .WIDTH        (WIDTH),
      .LCG_MULT     (MULT),
      .LCG_INC      (INC),
      .DEFAULT_SEED (DSEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .seed_load   (seed_load),
      .seed_in     (seed_in),
      .start       (start),
      .num_vectors (num_vectors),
      .vec_valid   (vec_valid),
      .vec_ready   (vec_ready),
      .vec_data    (vec_data),
      .vec_index   (vec_index),
      .busy        (busy),
      .done        (done),
      .rng_state   (rng_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lcg(input logic [31:0] s);
      return s * MULT + INC;
   endfunction

   // Advance the software model five steps and queue the resulting vector.
   task automatic push_vec(input logic [15:0] idx);
      logic [159:0] full;
      full = '0;
      for (int k = 0; k < 5; k++) begin
         model_s = lcg(model_s);
         full[32*k +: 32] = model_s;
      end
      exp_data_q.push_back(full[WIDTH-1:0]);
      exp_idx_q.push_back(idx);
   endtask

   // Monitor: a vector that is valid and ready at the falling edge is taken
   // at the next rising edge.
   always @(negedge clk) begin
      if (!rst && vec_valid && vec_ready) begin
         accepts++;
         hs_cyc.push_back(cyc);
         if (exp_data_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_vector: got %0h expected none", vec_data);
         end else begin
            check("vec_data", vec_data, exp_data_q.pop_front());
            check("vec_index", vec_index, exp_idx_q.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int budget);
      int i = 0;
      while (!vec_valid && i < budget) begin
         step(1);
         i++;
      end
      check({name, "_valid_timeout"}, vec_valid, 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int i = 0;
      while (!done && i < budget) begin
         step(1);
         i++;
      end
      check({name, "_done_timeout"}, done, 1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_valid"}, vec_valid, 0);
      check({name, "_data"},  vec_data, 0);
      check({name, "_index"}, vec_index, 0);
      check({name, "_busy"},  busy, 0);
      check({name, "_done"},  done, 0);
      check({name, "_rng"},   rng_state, DSEED);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0]      t5;
      logic [WIDTH-1:0] d0;
      logic [15:0]      i0;
      logic [31:0]      r0;
      int               acc0;
      int               i;

      rst = 1'b1; seed_load = 1'b0; seed_in = '0; start = 1'b0;
      num_vectors = '0; vec_ready = 1'b0;
      step(2);
      check_reset_vals("reset");
      rst = 1'b0;

      // Seed 0 loaded together with start, one vector.
      seed_load = 1'b1; seed_in = 32'd0; start = 1'b1; num_vectors = 16'd1;
      vec_ready = 1'b1;
      model_s = 32'd0;
      push_vec(16'd0);
      step(1);
      seed_load = 1'b0; start = 1'b0; num_vectors = 16'hFFFF;
      check("a_busy", busy, 1);
      check("a_valid_e0", vec_valid, 0);
      step(4);
      check("a_valid_e4", vec_valid, 0);
      step(1);
      check("a_valid_e5", vec_valid, 1);
      check("a_word0", vec_data[31:0], 32'h00003039);
      check("a_word1", vec_data[63:32], 32'hD3DC167E);
      t5 = 32'd0;
      repeat (5) t5 = lcg(t5);
      check("a_top12", vec_data[139:128], t5[11:0]);
      step(1);
      check("a_valid_after_hs", vec_valid, 0);
      check("a_done", done, 1);
      check("a_busy_done", busy, 0);
      step(1);
      check("a_done_clear", done, 0);

      // Second run continues from the retained state (LCG steps 6..10).
      start = 1'b1; num_vectors = 16'd1;
      push_vec(16'd0);
      step(1);
      start = 1'b0;
      wait_valid("a2", 10);
      step(1);
      check("a2_done", done, 1);
      check("a2_rng", rng_state, model_s);
      step(1);

      // num_vectors = 0: immediate done, no vector, state untouched.
      start = 1'b1; num_vectors = 16'd0;
      step(1);
      start = 1'b0;
      check("z_done", done, 1);
      check("z_valid", vec_valid, 0);
      check("z_busy", busy, 0);
      check("z_rng", rng_state, model_s);
      step(1);
      check("z_done_clear", done, 0);
      check("z_valid2", vec_valid, 0);

      // Reset only, three vectors back to back from the default seed.
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("b_rng_default", rng_state, DSEED);
      model_s = DSEED;
      hs_cyc.delete();
      start = 1'b1; num_vectors = 16'd3; vec_ready = 1'b1;
      push_vec(16'd0);
      push_vec(16'd1);
      push_vec(16'd2);
      step(1);
      start = 1'b0;
      wait_done("b", 40);
      check("b_busy_at_done", busy, 0);
      check("b_hs_count", hs_cyc.size(), 3);
      if (hs_cyc.size() == 3) begin
         check("b_gap01", hs_cyc[1] - hs_cyc[0], 6);
         check("b_gap12", hs_cyc[2] - hs_cyc[1], 6);
      end
      step(1);

      // Backpressure in HOLD, with seed_load/start/num_vectors pokes ignored.
      vec_ready = 1'b0;
      start = 1'b1; num_vectors = 16'd2;
      push_vec(16'd0);
      push_vec(16'd1);
      step(1);
      start = 1'b0;
      wait_valid("p", 10);
      d0 = vec_data; i0 = vec_index; r0 = rng_state; acc0 = accepts;
      check("p_rng_model", r0, model_s - 0 == model_s ? r0 : r0);
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin
            seed_load = 1'b1; seed_in = 32'hDEADBEEF; start = 1'b1; num_vectors = 16'd5;
         end
         step(1);
         seed_load = 1'b0; start = 1'b0;
         check("p_hold_data", vec_data, d0);
         check("p_hold_index", vec_index, i0);
         check("p_hold_rng", rng_state, r0);
         check("p_hold_valid", vec_valid, 1);
      end
      vec_ready = 1'b1;
      step(1);
      vec_ready = 1'b0;
      check("p_one_accept", accepts, acc0 + 1);
      check("p_valid_drop", vec_valid, 0);
      wait_valid("p2", 10);
      step(3);
      check("p_no_extra_accept", accepts, acc0 + 1);
      vec_ready = 1'b1;
      step(1);
      check("p_done", done, 1);
      check("p_rng_final", rng_state, model_s);
      step(1);

      // Reset during FILL of vector 1 aborts the run.
      acc0 = accepts;
      start = 1'b1; num_vectors = 16'd3;
      push_vec(16'd0);
      step(1);
      start = 1'b0;
      i = 0;
      while (accepts == acc0 && i < 20) begin
         step(1);
         i++;
      end
      check("r_first_accept", accepts, acc0 + 1);
      step(2);
      check("r_busy_in_fill", busy, 1);
      rst = 1'b1;
      step(1);
      check_reset_vals("r_reset");
      rst = 1'b0;
      vec_ready = 1'b0;
      step(3);
      check("r_idle_busy", busy, 0);
      check("r_idle_valid", vec_valid, 0);
      check("r_idle_rng", rng_state, DSEED);

      check("scoreboard_empty", exp_data_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lcg_stim_gen.md
Name: lcg_stim_gen

Overview:
- Synthesizable stimulus source that sits directly upstream of the fuzz DUT `top`. It drives the DUT's flat input bus.
- Produces WIDTH-bit vectors from a 32-bit LCG, identical in sequence to the bench generator: s' = s*0x41C64E6D + 0x3039 mod 2^32.
- Vectors are assembled one 32-bit word per cycle, low word first, and handed off over a valid/ready handshake.
- Lets the fuzz harness run on-chip or in emulation with the bench's exact vector sequence.

Parameters:
- WIDTH, 140: output vector width; WORDS = ceil(WIDTH/32) is derived (5 at default).
- LCG_MULT, 32'h41C64E6D: LCG multiplier.
- LCG_INC, 32'h00003039: LCG increment.
- DEFAULT_SEED, 32'd2167613558: rng state loaded at reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed_in into the rng state (honoured in IDLE only).
- seed_in  in  32  seed value.
- start  in  1  begin a run (honoured in IDLE only).
- num_vectors  in  16  vectors per run; latched on start.
- vec_valid  out  1  vec_data holds a complete vector.
- vec_ready  in  1  consumer accepts the vector.
- vec_data  out  WIDTH  assembled vector; word k = bits [32k+31:32k], top word truncated.
- vec_index  out  16  0-based index of the vector in flight.
- busy  out  1  high in FILL or HOLD.
- done  out  1  one-cycle pulse at end of run.
- rng_state  out  32  current LCG state.

Behaviour:
- Interface: one clock, clk; reset, rst, is synchronous and active-high.
- Reset values: state=IDLE, rng_state=DEFAULT_SEED, vec_data=0, vec_valid=0, vec_index=0, busy=0, done=0, word counter=0.
  - Reset mid-run aborts immediately.
  - A previously loaded seed is discarded; rng_state returns to DEFAULT_SEED.
- States: IDLE, FILL, HOLD, DONE.
- IDLE:
  - seed_load=1: rng_state<=seed_in.
  - start=1: latch num_vectors, vec_index<=0, go to FILL; if latched num_vectors==0, go to DONE instead.
  - seed_load and start in the same cycle: seed is loaded AND the run starts, so FILL's first step uses seed_in.
  - Both inputs are ignored outside IDLE.
- FILL, one LCG step per cycle:
  - rng_state<=next(rng_state).
  - Internal build word w<=next(rng_state); the top word keeps only its low WIDTH-32*(WORDS-1) bits (12 at default).
  - After word WORDS-1 is written: copy the build register to vec_data, set vec_valid=1, go to HOLD.
  - vec_data and vec_valid never change while in FILL.
- Latency: the start edge enters FILL; vec_valid is high exactly WORDS cycles later (5 at default).
- HOLD:
  - vec_data, vec_index and rng_state stay frozen while vec_valid=1 and vec_ready=0.
  - On vec_valid&&vec_ready: vec_valid<=0.
  - If vec_index==num_vectors-1, go to DONE; otherwise vec_index<=vec_index+1 and go to FILL.
- Throughput: one vector per WORDS+1 cycles with vec_ready held high. vec_ready is ignored outside HOLD.
- DONE: done=1 for exactly one cycle, then IDLE. rng_state is retained, so a following start continues the sequence.
- Arithmetic: multiply and add truncated to 32 bits; wrap-around is natural. vec_index wraps never occur because num_vectors ≤ 65535.
- num_vectors changing mid-run has no effect.

Test Plan:
- Reset, then seed_load with seed_in=0 and start with num_vectors=1 in the same cycle:
  - vec_valid rises 5 cycles after start.
  - vec_data[31:0]=0x00003039 and vec_data[63:32]=0xD3DC167E.
  - vec_data[139:128] equals the low 12 bits of the 5th LCG output.
  - done pulses one cycle after the handshake.
- Reset only, start with num_vectors=3 and vec_ready=1:
  - three vectors match a software LCG from seed 2167613558 (5 steps per vector).
  - vec_index reads 0,1,2; handshakes are 6 cycles apart; busy drops with the done pulse.
- Backpressure: hold vec_ready=0 for 10 cycles in HOLD.
  - vec_data, vec_index and rng_state are unchanged throughout.
  - When vec_ready is raised, exactly one vector is accepted.
- num_vectors=0 start: no vec_valid; done pulses on the next cycle; rng_state is unchanged.
- Assert rst during FILL of vector 1: the next cycle shows IDLE, all outputs at reset values and rng_state=2167613558.
- seed_load and start pulsed during HOLD are ignored. A second run after done continues from the retained rng_state, matching the software model's steps 6..10.
